count_compare_timer: RTL and testbench
======================================

// Module: count_compare_timer
// PURPOSE
//  Downstream consumer of the free-running simple_counter count bus.
//  Schedules an event DELTA ticks after being armed and pulses irq when it elapses.
//  Supports one-shot or drift-free periodic mode.
//  Sits between the counter and interrupt/control logic; no internal timebase.
// PARAMETERS
//  WIDTH      32  width of count_in / cfg_delta (matches counter output)
//  FCNT_W     8   width of fire_cnt event counter
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  count_in      in   WIDTH   current counter value, sampled every clk
//  cfg_valid     in   1       arm request
//  cfg_ready     out  1       arm accepted when cfg_valid & cfg_ready
//  cfg_delta     in   WIDTH   ticks until event; 0 treated as 1
//  cfg_periodic  in   1       1 = rearm automatically after each fire
//  cancel        in   1       disarm request
//  busy          out  1       timer armed
//  irq           out  1       one-cycle event pulse, registered
//  overrun       out  1       sticky: periodic period missed; cleared by next accepted arm
//  fire_cnt      out  FCNT_W  number of fires since reset, wraps at 2^FCNT_W
// BEHAVIOUR
//  Reset:
//  - Asynchronous on rst high: state=IDLE; irq, overrun, fire_cnt, busy = 0.
//  - Internal base, delta and periodic registers = 0.
//  States:
//  - IDLE (cfg_ready=1, busy=0) and ARMED (cfg_ready=0, busy=1).
//  - cfg_ready is a combinational decode of state, so it is 1 during reset.
//  IDLE -> ARMED:
//  - On cfg_valid & cfg_ready, capture base<=count_in, delta<=max(cfg_delta,1) and periodic.
//  - Clear overrun in the same cycle.
//  Elapse rule (modular):
//  - elapsed = (count_in - base) mod 2^WIDTH; fire when elapsed >= delta.
//  - Counter wrap-around is therefore transparent.
//  - If the upstream counter is reset while ARMED, elapsed jumps large and the timer fires.
//    This fail-safe is required behaviour.
//  Fire cycle (ARMED, condition true, no cancel):
//  - irq=1 on the next cycle for exactly one cycle; fire_cnt increments.
//  - One-shot: next state IDLE.
//  - Periodic: stay ARMED with base<=base+delta (no drift).
//    If elapsed >= 2*delta, set overrun=1 and base<=count_in (resync), firing once, not catching up.
//  Latency:
//  - Arm accepted in cycle N with count_in=C, counter +1/cycle.
//  - count_in reaches C+D in cycle N+D; irq is high in cycle N+D+1.
//  Cancel:
//  - In ARMED: next state IDLE, no irq.
//  - Cancel and fire in the same cycle: cancel wins (no irq, fire_cnt unchanged).
//  - In IDLE: ignored; a simultaneous cfg_valid is still accepted.
//  Arithmetic:
//  - All subtraction and addition is WIDTH-bit, unsigned, with no carry out.
//  - The 2*delta comparison uses WIDTH+1 bits.
//  Reset mid-operation:
//  - Any in-flight irq is dropped; the block comes up in IDLE.
// STRUCTURE
//  Shared package timer_pkg holds:
//  - State typedef/localparams (IDLE=1'b0, ARMED=1'b1).
//  - Default WIDTH=32.
//  One natural sub-module: wrap_elapsed_cmp.
//  - Combinational modular subtract plus the >=delta and >=2*delta compares.
//  - Reusable by other timers.
//  The rest is a single registered FSM and datapath.
// TESTING
//  Drive count_in from a simple_counter instance; clk period 10 ns; release rst at 15 ns.
//  1. Arm D=5 at count=3, one-shot -> irq single pulse when count_in has been 8;
//     then busy=0, fire_cnt=1.
//  2. Arm D=4 periodic at count=10 -> irq one cycle after count=14, 18, 22;
//     fire_cnt=3 after three fires; overrun stays 0.
//  3. Force count_in=32'hFFFF_FFFE, arm D=3 -> fires after count_in=1 (wrap), exactly once.
//  4. Cancel in the same cycle the fire condition first holds -> no irq; state IDLE; fire_cnt unchanged.
//  5. Periodic D=2, hold count_in, then jump it by +7 -> single irq, overrun=1, base=new count.
//     Re-arm clears overrun.
//  6. Assert rst while ARMED one cycle before fire -> irq never asserts.
//     All outputs 0 and cfg_ready=1 immediately (asynchronous).
//  7. cfg_delta=0 -> behaves as D=1.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default widths for count/compare timers
package timer_pkg;
    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_FCNT_W = 8;
endpackage

// File: rtl/wrap_elapsed_cmp.sv
// wrap_elapsed_cmp: modular elapsed-time compare against delta and 2*delta
module wrap_elapsed_cmp
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] delta,
    output logic             ge_delta,
    output logic             ge_2delta
);
    logic [WIDTH-1:0] elapsed;
    assign elapsed   = count - base;
    assign ge_delta  = elapsed >= delta;
    // one extra bit so 2*delta cannot overflow
    assign ge_2delta = {1'b0, elapsed} >= {delta, 1'b0};
endmodule

// File: rtl/count_compare_timer.sv
// count_compare_timer: one-shot/periodic event scheduler driven by an external count bus
module count_compare_timer
    import timer_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int FCNT_W = DEFAULT_FCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_delta,
    input  logic              cfg_periodic,
    input  logic              cancel,
    output logic              busy,
    output logic              irq,
    output logic              overrun,
    output logic [FCNT_W-1:0] fire_cnt
);
    state_t state, state_nx;
    logic [WIDTH-1:0] base, delta;
    logic periodic, ge_delta, ge_2delta, accept, fire;

    wrap_elapsed_cmp #(.WIDTH(WIDTH)) u_cmp (
        .count    (count_in),
        .base     (base),
        .delta    (delta),
        .ge_delta (ge_delta),
        .ge_2delta(ge_2delta)
    );

    assign cfg_ready = state == IDLE;
    assign busy      = state == ARMED;
    assign accept    = cfg_valid & cfg_ready;
    assign fire      = busy & ge_delta & ~cancel;

    always_comb begin
        state_nx = accept ? ARMED : (busy && (cancel || (fire && !periodic))) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base     <= '0;
            delta    <= '0;
            periodic <= 1'b0;
            irq      <= 1'b0;
            overrun  <= 1'b0;
            fire_cnt <= '0;
        end else begin
            irq <= fire;
            if (fire) fire_cnt <= fire_cnt + FCNT_W'(1);
            if (accept) begin
                base     <= count_in;
                delta    <= (cfg_delta == '0) ? WIDTH'(1) : cfg_delta;
                periodic <= cfg_periodic;
                overrun  <= 1'b0;
            end else if (fire && periodic) begin
                // a missed period resyncs to now instead of firing a burst of catch-up events
                base <= ge_2delta ? count_in : base + delta;
                if (ge_2delta) overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_count_compare_timer.sv
// tb_count_compare_timer: directed vector table plus an async-reset sequence
module tb_count_compare_timer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] count_in;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_delta;
    logic        cfg_periodic;
    logic        cancel;
    logic        busy;
    logic        irq;
    logic        overrun;
    logic [7:0]  fire_cnt;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [31:0] cnt;
        logic        valid;
        logic [31:0] delta;
        logic        per;
        logic        cncl;
        logic        irq;
        logic        busy;
        logic        ov;
        logic [7:0]  fc;
    } vec_t;

    vec_t vecs[$];

    count_compare_timer #(.WIDTH(32), .FCNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_delta   (cfg_delta),
        .cfg_periodic(cfg_periodic),
        .cancel      (cancel),
        .busy        (busy),
        .irq         (irq),
        .overrun     (overrun),
        .fire_cnt    (fire_cnt)
    );

    always #5 clk = ~clk;

    function automatic void add(logic [31:0] c, logic v, logic [31:0] d, logic p, logic x,
                                logic ei, logic eb, logic eo, logic [7:0] ef);
        vecs.push_back('{c, v, d, p, x, ei, eb, eo, ef});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ei, input logic eb, input logic eo, input logic [7:0] ef);
        chk({tag, ".irq"}, 32'(irq), 32'(ei));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!eb));
        chk({tag, ".overrun"}, 32'(overrun), 32'(eo));
        chk({tag, ".fire_cnt"}, 32'(fire_cnt), 32'(ef));
    endtask

    task automatic step(input logic [31:0] c, input logic v, input logic [31:0] d, input logic p, input logic x);
        @(negedge clk);
        count_in = c;
        cfg_valid = v;
        cfg_delta = d;
        cfg_periodic = p;
        cancel = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        count_in = '0;
        cfg_valid = 1'b0;
        cfg_delta = '0;
        cfg_periodic = 1'b0;
        cancel = 1'b0;
        // one-shot D=5 at count 3
        add(3, 1, 5, 0, 0, 0, 1, 0, 0);
        for (int c = 4; c <= 7; c++) add(c, 0, 0, 0, 0, 0, 1, 0, 0);
        add(8, 0, 0, 0, 0, 1, 0, 0, 1);
        add(9, 0, 0, 0, 0, 0, 0, 0, 1);
        // periodic D=4 at count 10, fires at 14/18/22
        add(10, 1, 4, 1, 0, 0, 1, 0, 1);
        for (int c = 11; c <= 22; c++) add(c, 0, 0, 0, 0, c % 4 == 2, 1, 0, 8'(1 + (c - 10) / 4));
        add(23, 0, 0, 0, 1, 0, 0, 0, 4);
        // wrap-around
        add(32'hFFFF_FFFE, 1, 3, 0, 0, 0, 1, 0, 4);
        add(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0, 4);
        add(0, 0, 0, 0, 0, 0, 1, 0, 4);
        add(1, 0, 0, 0, 0, 1, 0, 0, 5);
        add(2, 0, 0, 0, 0, 0, 0, 0, 5);
        // delta 0 acts as 1
        add(100, 1, 0, 0, 0, 0, 1, 0, 5);
        add(101, 0, 0, 0, 0, 1, 0, 0, 6);
        add(102, 0, 0, 0, 0, 0, 0, 0, 6);
        // cancel on the fire cycle
        add(200, 1, 2, 0, 0, 0, 1, 0, 6);
        add(201, 0, 0, 0, 0, 0, 1, 0, 6);
        add(202, 0, 0, 0, 1, 0, 0, 0, 6);
        add(203, 0, 0, 0, 0, 0, 0, 0, 6);
        // periodic overrun and resync, then re-arm clears it
        add(300, 1, 2, 1, 0, 0, 1, 0, 6);
        add(300, 0, 0, 0, 0, 0, 1, 0, 6);
        add(300, 0, 0, 0, 0, 0, 1, 0, 6);
        add(307, 0, 0, 0, 0, 1, 1, 1, 7);
        add(308, 0, 0, 0, 0, 0, 1, 1, 7);
        add(309, 0, 0, 0, 0, 1, 1, 1, 8);
        add(310, 0, 0, 0, 1, 0, 0, 1, 8);
        add(400, 1, 10, 0, 0, 0, 1, 0, 8);
        add(401, 0, 0, 0, 1, 0, 0, 0, 8);
        // cancel in IDLE is ignored, simultaneous arm accepted
        add(500, 1, 1, 0, 1, 0, 1, 0, 8);
        add(501, 0, 0, 0, 0, 1, 0, 0, 9);
        // upstream counter reset while armed fires
        add(1000, 1, 100, 0, 0, 0, 1, 0, 9);
        add(0, 0, 0, 0, 0, 1, 0, 0, 10);
        add(1, 0, 0, 0, 0, 0, 0, 0, 10);

        #12;
        chk_all("reset", 0, 0, 0, 0);
        #3 rst = 1'b0;

        foreach (vecs[i])
        begin
            step(vecs[i].cnt, vecs[i].valid, vecs[i].delta, vecs[i].per, vecs[i].cncl);
            chk_all($sformatf("v%0d", i), vecs[i].irq, vecs[i].busy, vecs[i].ov, vecs[i].fc);
        end

        // async reset one cycle before fire
        step(600, 1, 3, 0, 0);
        chk_all("rst_arm", 0, 1, 0, 10);
        step(601, 0, 0, 0, 0);
        step(602, 0, 0, 0, 0);
        chk_all("rst_pre", 0, 1, 0, 10);
        @(negedge clk);
        count_in = 603;
        #2 rst = 1'b1;
        #1;
        chk_all("rst_async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_edge", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(604, 0, 0, 0, 0);
        chk_all("rst_after", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
